hazard_scoreboard: RTL and testbench

- Parametrised successor to the ID-stage load-use hazard detector for the pipelined CPU.
- Replaces fixed EX/MEM rd comparisons with a per-register countdown scoreboard, so producers of any latency (load, multi-cycle multiply/divide) stall dependent consumers for exactly the cycles required.
- Also handles the ECALL implicit register read, a global pipeline hold (cache miss), branch flush, and a stall-cycle statistics counter.
- Sits beside the ID stage; drives PC write enable, IF/ID write enable, and ID/EX bubble insert.

---
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register latency countdown that stalls dependent consumers,
// with pipeline hold, flush squash and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned LAT_W     = 3,
    parameter int unsigned ECALL_REG = 17,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_ecall,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic [LAT_W-1:0]  id_latency,
    input  logic              pipe_hold,
    input  logic              flush,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic [STAT_W-1:0] stall_cycles
);

    logic [LAT_W-1:0]  r_cnt [NUM_REGS];
    logic [STAT_W-1:0] r_stall;

    logic w_busy;
    logic w_hazard;
    logic w_issue;

    // Register 0 is skipped and addresses >= NUM_REGS never match any entry.
    always_comb begin
        w_busy = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (r_cnt[r] != '0) begin
                if (id_use_rs1 && (id_rs1 == REG_AW'(r))) w_busy = 1'b1;
                if (id_use_rs2 && (id_rs2 == REG_AW'(r))) w_busy = 1'b1;
                if (id_is_ecall && (ECALL_REG == r))      w_busy = 1'b1;
            end
        end
    end

    assign w_hazard = id_valid && !flush && w_busy;
    assign w_issue  = id_valid && !flush && !w_hazard && !pipe_hold && id_reg_write &&
                      (id_rd != '0);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if (pipe_hold) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (w_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // A new issue overwrites any in-flight count: consumers forward from the youngest producer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else if (!pipe_hold) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (w_issue && (id_rd == REG_AW'(r))) begin
                    r_cnt[r] <= id_latency;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_hazard && !pipe_hold && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: ready-time reference model compared every cycle,
// directed latency/ECALL/hold/WAW/flush/reset scenarios, then randomized traffic.
module tb_hazard_scoreboard;

    localparam int NR = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       id_valid, id_use_rs1, id_use_rs2, id_is_ecall, id_reg_write, pipe_hold, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [2:0] id_latency;
    logic       pc_write, if_id_write, id_ex_bubble;
    logic       pc_write_s, if_id_write_s, id_ex_bubble_s;
    logic [15:0] stall_cycles;
    logic [1:0]  stall_sat;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_ecall(id_is_ecall),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_latency(id_latency),
        .pipe_hold(pipe_hold), .flush(flush), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(.STAT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_ecall(id_is_ecall),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_latency(id_latency),
        .pipe_hold(pipe_hold), .flush(flush), .pc_write(pc_write_s),
        .if_id_write(if_id_write_s), .id_ex_bubble(id_ex_bubble_s), .stall_cycles(stall_sat)
    );

    // Model: a register is busy until the count of non-held edges reaches its ready time.
    int unsigned m_active = 0;
    int unsigned m_ready [NR];
    int unsigned m_stalls = 0;
    int unsigned m_stalls_sat = 0;

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 0) && (int'(a) < NR) && (m_active < m_ready[a]);
    endfunction

    function automatic bit m_hazard();
        return id_valid && !flush && ((id_use_rs1 && m_busy(id_rs1)) ||
               (id_use_rs2 && m_busy(id_rs2)) || (id_is_ecall && m_busy(5'd17)));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) m_ready[i] <= 0;
            m_active     <= 0;
            m_stalls     <= 0;
            m_stalls_sat <= 0;
        end else if (!pipe_hold) begin
            if (m_hazard()) begin
                m_stalls     <= (m_stalls < 65535) ? m_stalls + 1 : m_stalls;
                m_stalls_sat <= (m_stalls_sat < 3) ? m_stalls_sat + 1 : m_stalls_sat;
            end else if (id_valid && !flush && id_reg_write && id_rd != 0) begin
                m_ready[id_rd] <= m_active + 1 + id_latency;
            end
            m_active <= m_active + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic eh;
            eh = m_hazard();
            chk("pc_write", pc_write, !pipe_hold && !eh);
            chk("if_id_write", if_id_write, !pipe_hold && !eh);
            chk("id_ex_bubble", id_ex_bubble, !pipe_hold && eh);
            chk("stall_cycles", stall_cycles, m_stalls);
            chk("stall_sat", stall_sat, m_stalls_sat);
        end
    end

    task automatic idle();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_ecall = 0; id_reg_write = 0;
        pipe_hold = 0; flush = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_latency = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (8) tick();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        id_valid = 1; id_reg_write = 1; id_rd = rd; id_latency = lat;
        tick();
        idle();
    endtask

    task automatic set_consumer(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic ec);
        idle();
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_is_ecall = ec;
    endtask

    // Counts bubble cycles for the consumer; bounded so a stuck stall cannot hang the run.
    task automatic consume(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic ec, output int n);
        n = 0;
        set_consumer(rs1, u1, rs2, u2, ec);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!id_ex_bubble) break;
            n++;
            tick();
        end
        tick();
        idle();
    endtask

    initial begin
        int n;
        logic [15:0] s0;
        idle();
        #1 reset_n = 0;
        #1;
        chk("rst pc_write", pc_write, 1);
        chk("rst if_id_write", if_id_write, 1);
        chk("rst bubble", id_ex_bubble, 0);
        chk("rst stall_cycles", stall_cycles, 0);
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        tick();

        issue(5'd6, 3'd5);
        consume(5'd6, 1, 5'd0, 0, 0, n);
        chk("lat5 bubbles", n, 5);
        chk("lat5 stall_cycles", stall_cycles, 5);
        chk("sat stall_cycles", stall_sat, 3);

        drain();
        s0 = stall_cycles;
        issue(5'd5, 3'd1);
        consume(5'd5, 1, 5'd0, 0, 0, n);
        chk("load-use bubbles", n, 1);
        chk("load-use stall delta", stall_cycles - s0, 1);

        drain();
        issue(5'd7, 3'd3);
        consume(5'd0, 0, 5'd7, 1, 0, n);
        chk("mul rs2 bubbles", n, 3);
        issue(5'd7, 3'd3);
        consume(5'd8, 1, 5'd0, 0, 0, n);
        chk("independent bubbles", n, 0);

        drain();
        issue(5'd17, 3'd2);
        consume(5'd0, 0, 5'd0, 0, 1, n);
        chk("ecall x17 bubbles", n, 2);
        drain();
        issue(5'd16, 3'd2);
        consume(5'd0, 0, 5'd0, 0, 1, n);
        chk("ecall x16 bubbles", n, 0);
        issue(5'd0, 3'd3);
        consume(5'd0, 1, 5'd0, 1, 0, n);
        chk("x0 producer bubbles", n, 0);

        drain();
        issue(5'd9, 3'd2);
        set_consumer(5'd9, 1, 5'd0, 0, 0);
        pipe_hold = 1;
        s0 = stall_cycles;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold bubble", id_ex_bubble, 0);
            chk("hold pc_write", pc_write, 0);
            tick();
        end
        chk("hold stall unchanged", stall_cycles, s0);
        consume(5'd9, 1, 5'd0, 0, 0, n);
        chk("post-hold bubbles", n, 2);

        drain();
        issue(5'd4, 3'd3);
        issue(5'd4, 3'd0);
        consume(5'd4, 1, 5'd0, 0, 0, n);
        chk("waw bubbles", n, 0);

        drain();
        issue(5'd4, 3'd3);
        set_consumer(5'd4, 1, 5'd0, 0, 0);
        flush = 1;
        @(negedge clk);
        chk("flush bubble", id_ex_bubble, 0);
        chk("flush pc_write", pc_write, 1);
        tick();

        drain();
        issue(5'd3, 3'd3);
        set_consumer(5'd3, 1, 5'd0, 0, 0);
        @(negedge clk);
        chk("pre-reset bubble", id_ex_bubble, 1);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("async rst pc_write", pc_write, 1);
        chk("async rst if_id_write", if_id_write, 1);
        chk("async rst bubble", id_ex_bubble, 0);
        chk("async rst stall_cycles", stall_cycles, 0);
        @(negedge clk);
        #2 reset_n = 1;
        @(negedge clk);
        chk("after rst no stall", id_ex_bubble, 0);
        tick();

        for (int i = 0; i < 3000; i++) begin
            id_valid     = ($urandom_range(0, 9) < 8);
            id_rs1       = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            id_rs2       = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            id_rd        = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            id_use_rs1   = 1'($urandom);
            id_use_rs2   = 1'($urandom);
            id_is_ecall  = ($urandom_range(0, 19) == 0);
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_latency   = 3'($urandom);
            pipe_hold    = ($urandom_range(0, 9) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            if (i % 16 == 5) id_rd = 5'd17;
            tick();
        end

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
